// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector: accepts words over valid/ready
// and shifts them out one bit per clock, streaming back-to-back words without a gap.
//
// state | meaning
// IDLE  | no word in flight, sdata parked at IDLE_BIT, ready for a word
// SHIFT | word bits on sdata; counter holds bits still to follow the current one
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             sdata,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             handshake;
    logic             load_bit;
    logic             shift_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

    assign word_ready = (state == IDLE) || (count == '0);
    assign handshake  = word_valid && word_ready;
    assign busy       = (state == SHIFT);

    // The bit to send next always sits at the output end of the shift register.
    assign load_bit   = MSB_FIRST ? word_in[WIDTH-1] : word_in[0];
    assign load_rest  = MSB_FIRST ? (word_in << 1) : (word_in >> 1);
    assign shift_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shift_rest = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sdata     <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
            count     <= '0;
            shreg     <= '0;
        end else if (handshake) begin
            state     <= SHIFT;
            sdata     <= load_bit;
            shreg     <= load_rest;
            count     <= CNT_LOAD;
            bit_valid <= 1'b1;
            word_done <= 1'b0;
        end else if (state == SHIFT && count != '0) begin
            sdata     <= shift_bit;
            shreg     <= shift_rest;
            count     <= count - CNT_ONE;
            bit_valid <= 1'b1;
            word_done <= (count == CNT_ONE);
        end else begin
            // Last bit gone with nothing queued behind it: park the line.
            state     <= IDLE;
            sdata     <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
        end
    end
endmodule
